atten_serial_driver: RTL and testbench
======================================

ATTEN_SERIAL_DRIVER -- requirements
Module: atten_serial_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5: SCLK half-period in ACLK cycles, legal range 1..255.
REQ-002 SHALL have parameter LE_CYCLES, default 4: latch-enable pulse width in ACLK cycles, legal range 1..255.
REQ-003 SHALL have parameter DATA_W, default 8: attenuation word width.
REQ-004 SHALL have port ACLK  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port ARESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  new attenuation word offered, from register-file write strobe.
REQ-007 SHALL have port in_ready  output  1  word accepted on a cycle where in_valid && in_ready.
REQ-008 SHALL have port in_data  input  DATA_W  attenuation code.
REQ-009 SHALL have port in_addr  input  8  device address; used only in addressed mode.
REQ-010 SHALL have port att_sclk  output  1  serial clock to attenuator.
REQ-011 SHALL have port att_sdata  output  1  serial data, LSB first.
REQ-012 SHALL have port att_le  output  1  latch enable.
REQ-013 SHALL have port busy  output  1  high while a word is serialising or latching.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of each latch.

Function
REQ-015 SHALL hold a one-deep pending buffer; in_ready = pending buffer empty.
REQ-016 SHALL move the buffered word into the shifter on the cycle after acceptance when the FSM is in IDLE, or on the cycle after done otherwise.
REQ-017 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-018 IDLE -> SHIFT_LO on load; att_sdata = bit 0; att_sclk = 0 for CLK_DIV cycles.
REQ-019 SHIFT_LO -> SHIFT_HI after CLK_DIV cycles; att_sclk = 1 for CLK_DIV cycles; att_sdata stable throughout.
REQ-020 SHIFT_HI -> SHIFT_LO with the next bit presented when bits remain; otherwise -> LATCH.
REQ-021 LATCH SHALL drive att_sclk = 0 and att_le = 1 for exactly LE_CYCLES cycles, then -> DONE.
REQ-022 DONE SHALL last one cycle with done = 1, att_le = 0, then -> SHIFT_LO if the pending buffer is full, else -> IDLE.
REQ-023 Frame length N SHALL be DATA_W bits; load-to-done latency SHALL be N*2*CLK_DIV + LE_CYCLES + 1 cycles.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 When in_valid is asserted while the buffer is full, the input SHALL be held off with in_ready = 0; no word is dropped or overwritten.
REQ-026 Simultaneous acceptance and buffer drain in one cycle SHALL keep the buffer full with the new word.
REQ-027 Bit and divider counters SHALL be saturation-free and sized ceil(log2(max+1)).

Reset
REQ-028 While ARESETN = 0: FSM = IDLE, buffer empty, att_sclk = 0, att_sdata = 0, att_le = 0, busy = 0, done = 0, in_ready = 0.
REQ-029 After deassertion, in_ready SHALL rise on the first ACLK edge.
REQ-030 Reset mid-frame SHALL abort the frame without any att_le pulse; the partial word is discarded.

Configuration
REQ-031 Macro ATTEN_ADDR_EN SHALL select addressed mode.
REQ-032 With ATTEN_ADDR_EN defined, the frame is in_data followed by in_addr, both LSB first, with N = DATA_W + 8.
REQ-033 Without ATTEN_ADDR_EN, in_addr is ignored and N = DATA_W.

Structure
REQ-034 Package atten_pkg SHALL hold the FSM state enum, default CLK_DIV/LE_CYCLES/DATA_W constants, and address width constant 8.
REQ-035 Sub-module atten_clk_div SHALL generate the CLK_DIV half-period tick and be instantiated once.

Verification
REQ-036 CLK_DIV=2, LE_CYCLES=4, DATA_W=8, write 0xA5 -> att_sdata bits 1,0,1,0,0,1,0,1 sampled on att_sclk rising edges; att_le high 4 cycles; done 37 cycles after load.
REQ-037 Back-to-back writes 0x01 then 0x7F while busy -> second accepted into the buffer; third write held (in_ready = 0) until the first done; frames are serialised in order.
REQ-038 ARESETN pulled low during bit 3 of 0xFF -> all outputs 0 immediately; no att_le pulse; a following write 0x10 serialises cleanly.
REQ-039 ATTEN_ADDR_EN defined, data 0x3C, addr 0x02 -> 16 SCLK rising edges carrying 0x3C LSB-first then 0x02 LSB-first; then one att_le pulse.
REQ-040 CLK_DIV=1, LE_CYCLES=1 boundary, write 0x80 -> SCLK toggles every cycle; load-to-done latency 18 cycles.

Source files
------------

// File: rtl/atten_pkg.sv
// Shared FSM encoding, default timing constants and frame sizing for the attenuator serial driver.
// Macro ATTEN_ADDR_EN widens each frame by the device address.
package atten_pkg;

  localparam int DEF_CLK_DIV   = 5;
  localparam int DEF_LE_CYCLES = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int ADDR_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } atten_state_e;

  function automatic int frame_len(input int data_w);
`ifdef ATTEN_ADDR_EN
    return data_w + ADDR_W;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/atten_clk_div.sv
// SCLK half-period tick: tick_o fires on every DIV-th enabled cycle; the count restarts whenever en_i drops.
module atten_clk_div #(
  parameter int DIV = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/atten_serial_driver.sv
// Serialises attenuation words LSB-first with SCLK and a latch pulse; ATTEN_ADDR_EN appends in_addr to the frame.
// Load-to-done is N*2*CLK_DIV+LE_CYCLES+1 cycles; one-deep buffer, in_ready low while it holds a word.
module atten_serial_driver
  import atten_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int LE_CYCLES = DEF_LE_CYCLES,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              att_sclk,
  output logic              att_sdata,
  output logic              att_le,
  output logic              busy,
  output logic              done
);

  localparam int N     = frame_len(DATA_W);
  localparam int BIT_W = $clog2(N + 1);
  localparam int LE_W  = $clog2(LE_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYCLES - 1);

  atten_state_e     state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic             pend_full_q, pend_full_d;
  logic             rdy_en_q;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LE_W-1:0]  le_cnt_q, le_cnt_d;
  logic [N-1:0]     frame;
  logic             half_tick, shifting, accept, load;

`ifdef ATTEN_ADDR_EN
  assign frame = {in_addr, in_data};
`else
  logic unused_addr;
  assign unused_addr = ^in_addr;
  assign frame       = in_data;
`endif

  // rdy_en_q keeps in_ready low through reset and lets it rise on the first edge after release.
  assign in_ready = rdy_en_q && !pend_full_q;
  assign accept   = in_valid && in_ready;
  assign shifting = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
  assign load     = pend_full_q && ((state_q == IDLE) || (state_q == DONE));

  atten_clk_div #(
    .DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i (ACLK),
    .rst_ni(ARESETN),
    .en_i  (shifting),
    .tick_o(half_tick)
  );

  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load) pend_full_d = 1'b0;
    if (accept) begin
      pend_full_d = 1'b1;
      pend_d      = frame;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    le_cnt_d  = le_cnt_q;
    att_sclk  = 1'b0;
    att_sdata = 1'b0;
    att_le    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        if (load) begin
          state_d   = SHIFT_LO;
          shreg_d   = pend_q;
          bit_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_LO: begin
        att_sdata = shreg_q[0];
        if (half_tick) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        att_sclk  = 1'b1;
        att_sdata = shreg_q[0];
        if (half_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = LATCH;
            le_cnt_d = '0;
          end else begin
            state_d   = SHIFT_LO;
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      LATCH: begin
        att_le = 1'b1;
        if (le_cnt_q == LE_LAST) state_d = DONE;
        else                     le_cnt_d = le_cnt_q + LE_W'(1);
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      le_cnt_q    <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      le_cnt_q    <= le_cnt_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_atten_serial_driver.sv
// Directed bench: a CLK_DIV=2/LE_CYCLES=4 instance and a CLK_DIV=1/LE_CYCLES=1 instance on one clock and reset.
module tb_atten_serial_driver;

`ifdef ATTEN_ADDR_EN
  localparam int         NB = 16;
  localparam logic [7:0] AM = 8'hFF;
`else
  localparam int         NB = 8;
  localparam logic [7:0] AM = 8'h00;
`endif
  localparam int LAT0 = NB * 2 * 2 + 4 + 1;
  localparam int LAT1 = NB * 2 * 1 + 1 + 1;

  logic       ACLK  = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, a0 = 8'h00, d1 = 8'h00, a1 = 8'h00;
  logic       r0, sclk0, sdat0, le0, busy0, done0;
  logic       r1, sclk1, sdat1, le1, busy1, done1;

  int   chk_cnt = 0, pass_cnt = 0;
  logic bits0[$];
  logic bits1[$];
  int   le_cyc0 = 0, le_pul0 = 0, done_cnt0 = 0;
  logic sclk0_p = 1'b0, sclk1_p = 1'b0, le0_p = 1'b0;

  always #5 ACLK = ~ACLK;

  atten_serial_driver #(.CLK_DIV(2), .LE_CYCLES(4), .DATA_W(8)) u_dut0 (
    .ACLK(ACLK), .ARESETN(rst_n), .in_valid(v0), .in_ready(r0), .in_data(d0), .in_addr(a0),
    .att_sclk(sclk0), .att_sdata(sdat0), .att_le(le0), .busy(busy0), .done(done0)
  );

  atten_serial_driver #(.CLK_DIV(1), .LE_CYCLES(1), .DATA_W(8)) u_dut1 (
    .ACLK(ACLK), .ARESETN(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_addr(a1),
    .att_sclk(sclk1), .att_sdata(sdat1), .att_le(le1), .busy(busy1), .done(done1)
  );

  always @(negedge ACLK) begin
    if (sclk0 && !sclk0_p) bits0.push_back(sdat0);
    if (sclk1 && !sclk1_p) bits1.push_back(sdat1);
    if (le0) le_cyc0++;
    if (le0 && !le0_p) le_pul0++;
    if (done0) done_cnt0++;
    sclk0_p = sclk0;
    sclk1_p = sclk1;
    le0_p   = le0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic logic [31:0] frm(input logic [7:0] d, input logic [7:0] a);
    return {16'h0000, a & AM, d};
  endfunction

  function automatic logic [31:0] word(input int sel, input int base, input int k);
    logic [31:0] w;
    int          idx;
    w = '0;
    for (int i = 0; i < NB; i++) begin
      idx = base + k * NB + i;
      if (sel == 0) begin
        if (idx < bits0.size()) w[i] = bits0[idx];
      end else if (idx < bits1.size()) begin
        w[i] = bits1[idx];
      end
    end
    return w;
  endfunction

  task automatic send0(input logic [7:0] d, input logic [7:0] a, output int w);
    v0 = 1'b1; d0 = d; a0 = a; w = 0;
    while (!r0 && w < 300) begin
      @(posedge ACLK); #1;
      w++;
    end
    @(posedge ACLK); #1;
    v0 = 1'b0;
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    do begin
      @(posedge ACLK); #1;
      n++;
    end while (!done0 && n < 300);
  endtask

  initial begin
    int          w, n, b, lp, lc, dc;
    logic [15:0] pat;

    #1;
    chk("rst_ready", 32'(r0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_sclk", 32'(sclk0), 0);
    chk("rst_sdata", 32'(sdat0), 0);
    chk("rst_le", 32'(le0), 0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(r0), 0);
    @(posedge ACLK); #1;
    chk("ready_first_edge", 32'(r0), 1);

    // 0xA5 on the CLK_DIV=2 instance: bits 1,0,1,0,0,1,0,1, four LE cycles, done 37 edges after acceptance
    b = bits0.size(); lp = le_pul0; lc = le_cyc0;
    send0(8'hA5, 8'h02, w);
    chk("a5_accept_wait", 32'(w), 0);
    wait_done0(n);
    chk("a5_latency", 32'(n), 32'(LAT0));
    chk("a5_nbits", 32'(bits0.size() - b), 32'(NB));
    chk("a5_word", word(0, b, 0), frm(8'hA5, 8'h02));
    chk("a5_le_cycles", 32'(le_cyc0 - lc), 4);
    chk("a5_le_pulses", 32'(le_pul0 - lp), 1);
    chk("a5_le_low_in_done", 32'(le0), 0);
    @(posedge ACLK); #1;
    chk("a5_done_one_cycle", 32'({done0, busy0}), 0);

    // CLK_DIV=1, LE_CYCLES=1: SCLK alternates every cycle, done 18 edges after acceptance
    b = bits1.size();
    v1 = 1'b1; d1 = 8'h80; a1 = 8'h00;
    chk("div1_ready", 32'(r1), 1);
    @(posedge ACLK); #1;
    v1 = 1'b0;
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge ACLK); #1;
      pat[i] = sclk1;
    end
    n = 16;
    while (!done1 && n < 300) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("div1_sclk_toggle", 32'(pat), 32'h0000_AAAA);
    chk("div1_latency", 32'(n), 32'(LAT1));
    chk("div1_word", word(1, b, 0), frm(8'h80, 8'h00));

    // Back-to-back: second word waits one cycle, third is held until the first frame's done
    b = bits0.size(); dc = done_cnt0;
    send0(8'h01, 8'h11, w);
    send0(8'h7F, 8'h22, w);
    chk("b2b_second_wait", 32'(w), 1);
    send0(8'h33, 8'h44, w);
    chk("b2b_third_held", 32'(w), 32'(LAT0 - 1));
    chk("b2b_done_before_ready", 32'(done_cnt0 - dc), 1);
    n = 0;
    while ((done_cnt0 - dc) < 3 && n < 400) begin
      @(posedge ACLK); #1;
      n++;
    end
    chk("b2b_frames_done", 32'(done_cnt0 - dc), 3);
    chk("b2b_word0", word(0, b, 0), frm(8'h01, 8'h11));
    chk("b2b_word1", word(0, b, 1), frm(8'h7F, 8'h22));
    chk("b2b_word2", word(0, b, 2), frm(8'h33, 8'h44));

    // Reset while bit 3 of 0xFF is on the wire (SCLK high phase)
    lp = le_pul0;
    send0(8'hFF, 8'h02, w);
    repeat (15) @(posedge ACLK);
    #1;
    chk("rst_mid_pre", 32'({sclk0, sdat0, busy0}), 7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({sclk0, sdat0, le0, busy0, done0, r0}), 0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    rst_n = 1'b1;
    @(posedge ACLK); #1;
    chk("rst_mid_no_le", 32'(le_pul0 - lp), 0);

    b = bits0.size(); lp = le_pul0;
    send0(8'h10, 8'h02, w);
    wait_done0(n);
    chk("post_rst_latency", 32'(n), 32'(LAT0));
    chk("post_rst_nbits", 32'(bits0.size() - b), 32'(NB));
    chk("post_rst_word", word(0, b, 0), frm(8'h10, 8'h02));
    chk("post_rst_le", 32'(le_pul0 - lp), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
